// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter and its fetch, data and memory neighbours.
// master: the arbiter's view; slave: the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_kill_i;
  logic [31:0]       if_rdata_o;
  logic              if_stall_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i;
  logic [3:0]        d_be_i;
  logic [31:0]       d_rdata_o;
  logic              d_stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              bus_err_o;

  modport master (
    input  if_req_i, if_addr_i, if_kill_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_rdata_o, if_stall_o, d_rdata_o, d_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, bus_err_o
  );

  modport slave (
    output if_req_i, if_addr_i, if_kill_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_rdata_o, if_stall_o, d_rdata_o, d_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, bus_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages, data has fixed priority.
// Optional response watchdog enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              squash_q, squash_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic timeout;
  logic resp_end;
  logic fetch_done;
  logic data_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside RESP, so it starts from zero on every entry to RESP.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_RESP) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout       = (state_q == S_RESP) && !bus.mem_rvalid_i && (cnt_q == CNT_LIM);
  assign bus.bus_err_o = timeout;
`else
  assign timeout       = 1'b0;
  assign bus.bus_err_o = 1'b0;
`endif

  assign resp_end   = (state_q == S_RESP) && (bus.mem_rvalid_i || timeout);
  assign fetch_done = resp_end && (owner_q == OWN_FETCH) && !squash_q;
  assign data_done  = resp_end && (owner_q == OWN_DATA);

  assign bus.if_stall_o = bus.if_req_i & ~fetch_done;
  assign bus.d_stall_o  = bus.d_req_i & ~data_done;
  // A watchdog completion releases the stall but returns zero data.
  assign bus.if_rdata_o = (fetch_done && bus.mem_rvalid_i) ? bus.mem_rdata_i : '0;
  assign bus.d_rdata_o  = (data_done && bus.mem_rvalid_i) ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_be_o    = be_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    squash_d = squash_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;

    case (state_q)
      S_IDLE: begin
        squash_d = 1'b0;
        if (bus.d_req_i) begin
          owner_d = OWN_DATA;
          req_d   = 1'b1;
          we_d    = bus.d_we_i;
          addr_d  = bus.d_addr_i;
          wdata_d = bus.d_wdata_i;
          be_d    = bus.d_be_i;
          state_d = S_REQ;
        end else if (bus.if_req_i && !bus.if_kill_i) begin
          owner_d = OWN_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.if_addr_i;
          be_d    = 4'hF;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (owner_q == OWN_FETCH && bus.if_kill_i) squash_d = 1'b1;
        if (bus.mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q == OWN_FETCH && bus.if_kill_i) squash_d = 1'b1;
        if (resp_end) begin
          squash_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_FETCH;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      squash_q <= squash_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, grant delay, kill, reset, IDLE kill,
// load, and (with MEM_ARB_TIMEOUT_EN) the response watchdog.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.if_req_i = 1'b0;  bus.if_addr_i = '0;  bus.if_kill_i = 1'b0;
    bus.d_req_i = 1'b0;   bus.d_we_i = 1'b0;   bus.d_addr_i = '0;
    bus.d_wdata_i = '0;   bus.d_be_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset values
    cyc(); cyc();
    #1;
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be_o), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err_o), 32'd0);
    chk("rst_if_stall_idle", 32'(bus.if_stall_o), 32'd0);
    bus.if_req_i = 1'b1; bus.d_req_i = 1'b1; bus.mem_rdata_i = 32'h9999_9999;
    #1;
    chk("rst_if_stall_follow", 32'(bus.if_stall_o), 32'd1);
    chk("rst_d_stall_follow", 32'(bus.d_stall_o), 32'd1);
    chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
    chk("rst_d_rdata", bus.d_rdata_o, 32'd0);
    bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
    cyc();

    // Fetch only
    rst = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    #1;
    chk("f_c0_stall", 32'(bus.if_stall_o), 32'd1);
    chk("f_c0_req", 32'(bus.mem_req_o), 32'd0);
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("f_c1_req", 32'(bus.mem_req_o), 32'd1);
    chk("f_c1_addr", bus.mem_addr_o, 32'h100);
    chk("f_c1_be", 32'(bus.mem_be_o), 32'hF);
    chk("f_c1_we", 32'(bus.mem_we_o), 32'd0);
    chk("f_c1_stall", 32'(bus.if_stall_o), 32'd1);
    cyc();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0050_0093;
    #1;
    chk("f_c2_req", 32'(bus.mem_req_o), 32'd0);
    chk("f_c2_stall", 32'(bus.if_stall_o), 32'd0);
    chk("f_c2_rdata", bus.if_rdata_o, 32'h0050_0093);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.if_req_i = 1'b0;
    #1;
    chk("f_c3_req", 32'(bus.mem_req_o), 32'd0);
    chk("f_c3_rdata", bus.if_rdata_o, 32'd0);

    // Collision: store wins, fetch 0x104 follows
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h2000;
    bus.d_wdata_i = 32'hDEAD_BEEF; bus.d_be_i = 4'hF;
    #1;
    chk("c_c0_if_stall", 32'(bus.if_stall_o), 32'd1);
    chk("c_c0_d_stall", 32'(bus.d_stall_o), 32'd1);
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("c_c1_req", 32'(bus.mem_req_o), 32'd1);
    chk("c_c1_we", 32'(bus.mem_we_o), 32'd1);
    chk("c_c1_addr", bus.mem_addr_o, 32'h2000);
    chk("c_c1_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    chk("c_c1_if_stall", 32'(bus.if_stall_o), 32'd1);
    cyc();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_1111;
    #1;
    chk("c_c2_d_stall", 32'(bus.d_stall_o), 32'd0);
    chk("c_c2_d_rdata", bus.d_rdata_o, 32'h1111_1111);
    chk("c_c2_if_stall", 32'(bus.if_stall_o), 32'd1);
    chk("c_c2_if_rdata", bus.if_rdata_o, 32'd0);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    #1;
    chk("c_c3_req", 32'(bus.mem_req_o), 32'd0);
    chk("c_c3_if_stall", 32'(bus.if_stall_o), 32'd1);
    cyc();

    // Fetch 0x104 issued at cycle 4; grant withheld for 4 cycles
    #1;
    chk("c_c4_req", 32'(bus.mem_req_o), 32'd1);
    chk("c_c4_addr", bus.mem_addr_o, 32'h104);
    chk("c_c4_we", 32'(bus.mem_we_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("g_req_hold", 32'(bus.mem_req_o), 32'd1);
      chk("g_addr_hold", bus.mem_addr_o, 32'h104);
      chk("g_stall_hold", 32'(bus.if_stall_o), 32'd1);
    end
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("g_gnt_req", 32'(bus.mem_req_o), 32'd1);
    cyc();

    // Kill during RESP; redirect to 0x200
    bus.mem_gnt_i = 1'b0; bus.if_kill_i = 1'b1; bus.if_addr_i = 32'h200;
    #1;
    chk("k_resp_req", 32'(bus.mem_req_o), 32'd0);
    chk("k_resp_stall", 32'(bus.if_stall_o), 32'd1);
    cyc();
    bus.if_kill_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("k_drop_stall", 32'(bus.if_stall_o), 32'd1);
    chk("k_drop_rdata", bus.if_rdata_o, 32'd0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("k_idle_req", 32'(bus.mem_req_o), 32'd0);
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("k_new_req", 32'(bus.mem_req_o), 32'd1);
    chk("k_new_addr", bus.mem_addr_o, 32'h200);
    cyc();

    // Reset in RESP, then stray rvalid
    bus.mem_gnt_i = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0055;
    #1;
    chk("r_req", 32'(bus.mem_req_o), 32'd0);
    chk("r_stray_stall", 32'(bus.if_stall_o), 32'd1);
    chk("r_stray_rdata", bus.if_rdata_o, 32'd0);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    chk("r_reissue_req", 32'(bus.mem_req_o), 32'd1);
    chk("r_reissue_addr", bus.mem_addr_o, 32'h200);
    cyc();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
    #1;
    chk("r_done_stall", 32'(bus.if_stall_o), 32'd0);
    chk("r_done_rdata", bus.if_rdata_o, 32'h1234_5678);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.if_req_i = 1'b0;

    // Kill in IDLE blocks a fetch for that cycle only
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300; bus.if_kill_i = 1'b1;
    cyc();
    bus.if_kill_i = 1'b0;
    #1;
    chk("ik_blocked_req", 32'(bus.mem_req_o), 32'd0);
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("ik_req", 32'(bus.mem_req_o), 32'd1);
    chk("ik_addr", bus.mem_addr_o, 32'h300);
    cyc();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
    #1;
    chk("ik_rdata", bus.if_rdata_o, 32'h0000_0013);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.if_req_i = 1'b0;

    // Load with partial byte enables
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h44; bus.d_be_i = 4'b0011;
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("ld_we", 32'(bus.mem_we_o), 32'd0);
    chk("ld_be", 32'(bus.mem_be_o), 32'h3);
    chk("ld_addr", bus.mem_addr_o, 32'h44);
    cyc();
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hA5A5_0000;
    #1;
    chk("ld_stall", 32'(bus.d_stall_o), 32'd0);
    chk("ld_rdata", bus.d_rdata_o, 32'hA5A5_0000);
    chk("ld_bus_err", 32'(bus.bus_err_o), 32'd0);
    cyc();
    bus.mem_rvalid_i = 1'b0; bus.d_req_i = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Load never answered: watchdog fires on the ninth RESP cycle (count 8)
    bus.d_req_i = 1'b1; bus.d_addr_i = 32'h48; bus.d_be_i = 4'hF;
    bus.mem_rdata_i = 32'h7777_7777;
    cyc();
    bus.mem_gnt_i = 1'b1;
    cyc();
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_err", 32'(bus.bus_err_o), 32'd0);
      chk("to_wait_stall", 32'(bus.d_stall_o), 32'd1);
      cyc();
    end
    #1;
    chk("to_err", 32'(bus.bus_err_o), 32'd1);
    chk("to_stall", 32'(bus.d_stall_o), 32'd0);
    chk("to_rdata", bus.d_rdata_o, 32'd0);
    cyc();
    bus.d_req_i = 1'b0;
    #1;
    chk("to_err_pulse", 32'(bus.bus_err_o), 32'd0);
    chk("to_idle_req", 32'(bus.mem_req_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the rv32 core between the instruction-fetch stage and the data-memory (MEM) stage. It holds one outstanding transaction at a time, gives the data port fixed priority, and returns per-stage stall requests to the hazard unit. It also supports squashing an in-flight fetch when the pipeline redirects.

## Interface
Parameters:
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, response watchdog limit (only used with MEM_ARB_TIMEOUT_EN)

Ports (clock and reset):
- clk_i  in  1  clock; everything is sampled on the rising edge
- rst_i  in  1  reset; synchronous, active-high

Fetch side:
- if_req_i  in  1  fetch request; held until the cycle if_stall_o is low
- if_addr_i  in  ADDR_W  fetch address
- if_kill_i  in  1  pipeline redirect (pc_src_e); squashes the pending fetch
- if_rdata_o  out  32  fetch data; valid when if_req_i=1 and if_stall_o=0
- if_stall_o  out  1  stall F/D

Data side:
- d_req_i  in  1  load/store request; held until d_stall_o is low
- d_we_i  in  1  store
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  32  store data
- d_be_i  in  4  byte enables
- d_rdata_o  out  32  load data; valid when d_stall_o=0
- d_stall_o  out  1  stall F/D/E/M

Memory side:
- mem_req_o  out  1  request; registered
- mem_we_o  out  1  registered
- mem_addr_o  out  ADDR_W  registered
- mem_wdata_o  out  32  registered
- mem_be_o  out  4  registered
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response (read data or write ack)
- mem_rdata_i  in  32  response data
- bus_err_o  out  1  one-cycle watchdog pulse

## Operation
State machine: IDLE, REQ, RESP. Registered owner flag: FETCH or DATA. Registered squash flag.
- **IDLE**
  - If d_req_i, latch the data-side fields, set owner=DATA and go to REQ.
  - Otherwise, if if_req_i (and if_kill_i is low), latch if_addr_i with we=0 and be=4'hF, set owner=FETCH and go to REQ.
- **REQ**
  - mem_req_o=1 and the latched fields are driven.
  - On mem_gnt_i, clear mem_req_o and go to RESP.
  - mem_req_o is never retracted before grant.
- **RESP**
  - On mem_rvalid_i, go to IDLE.
  - If owner=DATA, d_rdata_o=mem_rdata_i and d_stall_o=0 in that same cycle.
  - If owner=FETCH and squash=0, if_rdata_o=mem_rdata_i and if_stall_o=0 in that same cycle.
  - If owner=FETCH and squash=1, discard the data and keep if_stall_o at if_req_i.
- **Stalls** (combinational)
  - if_stall_o = if_req_i & ~fetch_done.
  - d_stall_o = d_req_i & ~data_done.
- **Kill**
  - if_kill_i while owner=FETCH in REQ or RESP sets squash.
  - squash clears on return to IDLE.
  - if_kill_i in IDLE does nothing; it also blocks a fetch from starting that cycle.
- **Simultaneous requests:** data wins. The fetch is served on the next IDLE pass.
- rdata outputs read 0 whenever they are not valid.

## Timing
- **Reset values:** state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, squash=0, bus_err_o=0, watchdog=0. Stall outputs follow their requests; rdata outputs are 0.
- **Minimum access:** request seen in IDLE at cycle 0 → mem_req_o at cycle 1 → gnt at cycle 1 → rvalid at the earliest at cycle 2 → stall low at cycle 2 → IDLE at cycle 3. Back-to-back accesses therefore take 3 cycles each.
- mem_rvalid_i arriving outside RESP is ignored.
- Reset in the middle of a transaction aborts it immediately; any later rvalid for it is ignored.

## Configuration
Macro: MEM_ARB_TIMEOUT_EN.
- **Defined:** a counter sized with $clog2(TIMEOUT_CYCLES+1) runs while in RESP and clears on entering RESP. When it reaches TIMEOUT_CYCLES without rvalid:
  - bus_err_o pulses for 1 cycle;
  - the owner's stall drops that cycle with rdata=0 (a squashed fetch stays stalled);
  - the state goes to IDLE.
- **Not defined:** RESP waits indefinitely. bus_err_o is tied to 0 and no counter is built.

## Test plan
- Fetch only: if_addr_i=0x100, gnt at cycle 1, rvalid at cycle 2 with 0x00500093 → mem_addr_o=0x100, mem_be_o=0xF, mem_we_o=0; at cycle 2 if_stall_o=0 and if_rdata_o=0x00500093.
- Collision: if_req_i and d_req_i both high in IDLE with d_we_i=1, d_addr_i=0x2000, d_wdata_i=0xDEADBEEF → the store is issued first; if_stall_o stays high through its ack, then the fetch issues 3 cycles later.
- Grant delay: gnt withheld for 4 cycles → mem_req_o and mem_addr_o stay stable all 4 cycles, and the stall holds until rvalid.
- Kill: if_kill_i pulses in RESP for fetch 0x104 → rvalid data is dropped and if_stall_o stays 1; the new fetch to 0x200 issues the cycle after returning to IDLE.
- Reset mid-RESP: rst_i high for 1 cycle → mem_req_o=0 and state IDLE; a stray rvalid is ignored.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: a load with no rvalid → at RESP cycle 8, bus_err_o=1 for one cycle, d_stall_o=0 and d_rdata_o=0.
